// File: rtl/arith_pkg.sv
// ---------------------------------------------------------------------------
// arith_pkg
//   Shared constants and helpers for the segmented arithmetic blocks.
//   - DEFAULT_WIDTH / DEFAULT_SEG_W : default operand width and segment width
//   - seg_cfg_ok()                  : legality test for a WIDTH/SEG_W pair,
//                                     used as an elaboration-time guard
// ---------------------------------------------------------------------------
package arith_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_SEG_W = 4;

    // A configuration is usable only when the word splits into whole segments.
    function automatic bit seg_cfg_ok(input int width, input int seg_w);
        return (width > 0) && (seg_w > 0) && ((width % seg_w) == 0);
    endfunction

endpackage

// File: rtl/seg_pipe_adder_if.sv
// ---------------------------------------------------------------------------
// seg_pipe_adder_if
//   Operand and result handshake bundle for seg_pipe_adder.
//   Operand side : in_valid, in_ready, a, b, c_in, sub
//   Result side  : out_valid, out_ready, s, c_out, ovf
//   Modports:
//     master - the producer/consumer environment around the adder
//     slave  - the adder itself
// ---------------------------------------------------------------------------
interface seg_pipe_adder_if
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             c_out;
    logic             ovf;

    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, s, c_out, ovf
    );

    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, s, c_out, ovf
    );

endinterface

// File: rtl/seg_add.sv
// ---------------------------------------------------------------------------
// seg_add
//   Combinational SEG_W-bit ripple-carry adder built from full-adder cells.
//   Ports:
//     a, b  : SEG_W-bit addends
//     cin   : carry into bit 0
//     s     : SEG_W-bit sum
//     cout  : carry out of the top bit
// ---------------------------------------------------------------------------
module seg_add
    import arith_pkg::*;
#(
    parameter int SEG_W = DEFAULT_SEG_W
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             cin,
    output logic [SEG_W-1:0] s,
    output logic             cout
);

    logic [SEG_W:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < SEG_W; i++) begin : g_fa
        assign s[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
    end

    assign cout = carry[SEG_W];

endmodule

// File: rtl/seg_pipe_adder.sv
// ---------------------------------------------------------------------------
// seg_pipe_adder
//   Segment-pipelined WIDTH-bit add/subtract unit. Each pipeline stage
//   resolves SEG_W bits with a ripple segment; the carry is registered
//   between stages. Latency is NSEG cycles, throughput one beat per cycle.
//   Ports:
//     clk  : rising-edge clock
//     rst  : synchronous active-high reset, clears all in-flight beats
//     bus  : seg_pipe_adder_if.slave
//            in_valid/in_ready/a/b/c_in/sub   operand beat
//            out_valid/out_ready/s/c_out/ovf  result beat
//   sub=0 : {c_out,s} = a + b + c_in
//   sub=1 : {c_out,s} = a + ~b + ~c_in  (c_out is the not-borrow)
//   ovf   : signed two's-complement overflow of the above
// ---------------------------------------------------------------------------
module seg_pipe_adder
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SEG_W = DEFAULT_SEG_W
) (
    input  logic             clk,
    input  logic             rst,
    seg_pipe_adder_if.slave  bus
);

    localparam int NSEG = WIDTH / SEG_W;
    localparam int MSB  = WIDTH - 1;

    if (!seg_cfg_ok(WIDTH, SEG_W)) begin : g_bad_cfg
        $error("seg_pipe_adder: WIDTH must be a positive multiple of SEG_W");
    end

    // Register k feeds stage k. Register 0 is the operand capture register;
    // the output register sits after stage NSEG-1, which gives NSEG cycles of
    // latency from accept to out_valid.
    logic [NSEG-1:0]  stg_v;
    logic [WIDTH-1:0] stg_a [NSEG];
    logic [WIDTH-1:0] stg_b [NSEG];
    logic [WIDTH-1:0] stg_s [NSEG];
    logic             stg_c [NSEG];

    logic             out_valid_q;
    logic [WIDTH-1:0] s_q;
    logic             c_q;
    logic             ovf_q;

    logic [SEG_W-1:0] seg_s [NSEG];
    logic             seg_c [NSEG];
    logic [WIDTH-1:0] nxt_s [NSEG];

    logic             adv;
    logic             accept;

    // The whole pipe moves as one; a stalled output freezes every stage, so
    // in_ready follows out_ready combinationally but never in_valid.
    assign adv          = ~out_valid_q | bus.out_ready;
    assign accept       = bus.in_valid & adv;
    assign bus.in_ready = adv;

    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        seg_add #(
            .SEG_W (SEG_W)
        ) u_seg_add (
            .a    (stg_a[k][k*SEG_W +: SEG_W]),
            .b    (stg_b[k][k*SEG_W +: SEG_W]),
            .cin  (stg_c[k]),
            .s    (seg_s[k]),
            .cout (seg_c[k])
        );
    end

    // Merge each stage's freshly resolved slice into the partial sum that
    // travels with the beat.
    always_comb begin
        for (int k = 0; k < NSEG; k++) begin
            nxt_s[k]                    = stg_s[k];
            nxt_s[k][k*SEG_W +: SEG_W]  = seg_s[k];
        end
    end

    // Pipeline registers. Valid bits shift on every advance so bubbles move
    // like data; payload registers load only behind a valid beat, which keeps
    // the held result quiet across bubbles and stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            stg_v       <= '0;
            out_valid_q <= 1'b0;
            s_q         <= '0;
            c_q         <= 1'b0;
            ovf_q       <= 1'b0;
            for (int k = 0; k < NSEG; k++) begin
                stg_a[k] <= '0;
                stg_b[k] <= '0;
                stg_s[k] <= '0;
                stg_c[k] <= 1'b0;
            end
        end else if (adv) begin
            stg_v[0] <= accept;
            if (accept) begin
                stg_a[0] <= bus.a;
                stg_b[0] <= bus.sub ? ~bus.b : bus.b;
                stg_c[0] <= bus.sub ? ~bus.c_in : bus.c_in;
                stg_s[0] <= '0;
            end

            for (int k = 1; k < NSEG; k++) begin
                stg_v[k] <= stg_v[k-1];
                if (stg_v[k-1]) begin
                    stg_a[k] <= stg_a[k-1];
                    stg_b[k] <= stg_b[k-1];
                    stg_s[k] <= nxt_s[k-1];
                    stg_c[k] <= seg_c[k-1];
                end
            end

            out_valid_q <= stg_v[NSEG-1];
            if (stg_v[NSEG-1]) begin
                s_q   <= nxt_s[NSEG-1];
                c_q   <= seg_c[NSEG-1];
                ovf_q <= (stg_a[NSEG-1][MSB] == stg_b[NSEG-1][MSB]) &&
                         (nxt_s[NSEG-1][MSB] != stg_a[NSEG-1][MSB]);
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.s         = s_q;
    assign bus.c_out     = c_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_seg_pipe_adder.sv
// ---------------------------------------------------------------------------
// tb_seg_pipe_adder
//   Directed self-checking bench for seg_pipe_adder at WIDTH=16, SEG_W=4.
//   Each task drives one scenario and compares against hand-computed values.
//   Inputs change 1 time unit after a rising edge; outputs are read there too.
// ---------------------------------------------------------------------------
module tb_seg_pipe_adder;
    import arith_pkg::*;

    localparam int W = 16;

    logic clk;
    logic rst;
    int   vecs;
    int   errs;

    seg_pipe_adder_if #(.WIDTH(W)) bus ();

    seg_pipe_adder #(
        .WIDTH (W),
        .SEG_W (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one beat with out_ready high and wait for its result.
    // Returns the observed latency (edges from accept to out_valid) and result.
    task automatic send_one(input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic ci, input logic sb,
                            output int lat, output logic [W-1:0] so,
                            output logic co, output logic ov);
        bus.out_ready = 1'b1;
        bus.a         = av;
        bus.b         = bv;
        bus.c_in      = ci;
        bus.sub       = sb;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = 16'hDEAD;
        bus.b        = 16'hBEEF;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        so = bus.s;
        co = bus.c_out;
        ov = bus.ovf;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.a         = '0;
        bus.b         = '0;
        bus.c_in      = 1'b0;
        bus.sub       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        vecs++;
        if (bus.out_valid !== 1'b0) begin
            errs++;
            $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid);
        end
        vecs++;
        if (bus.s !== 16'h0000) begin
            errs++;
            $display("[TB] FAIL reset_s: got %h expected 0000", bus.s);
        end
        vecs++;
        if (bus.c_out !== 1'b0) begin
            errs++;
            $display("[TB] FAIL reset_c_out: got %b expected 0", bus.c_out);
        end
        vecs++;
        if (bus.ovf !== 1'b0) begin
            errs++;
            $display("[TB] FAIL reset_ovf: got %b expected 0", bus.ovf);
        end
        vecs++;
        if (bus.in_ready !== 1'b1) begin
            errs++;
            $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        end
    endtask

    task automatic test_arith();
        logic [W-1:0] av [6];
        logic [W-1:0] bv [6];
        logic         ci [6];
        logic         sb [6];
        logic [W-1:0] es [6];
        logic         ec [6];
        logic         eo [6];
        int           lat;
        logic [W-1:0] so;
        logic         co;
        logic         ov;
        // plain add
        av[0] = 16'h1234; bv[0] = 16'h0FCD; ci[0] = 0; sb[0] = 0; es[0] = 16'h2201; ec[0] = 0; eo[0] = 0;
        // carry ripples through every segment
        av[1] = 16'hFFFF; bv[1] = 16'h0000; ci[1] = 1; sb[1] = 0; es[1] = 16'h0000; ec[1] = 1; eo[1] = 0;
        // subtract producing a borrow
        av[2] = 16'h0005; bv[2] = 16'h0007; ci[2] = 0; sb[2] = 1; es[2] = 16'hFFFE; ec[2] = 0; eo[2] = 0;
        // signed underflow on subtract
        av[3] = 16'h8000; bv[3] = 16'h0001; ci[3] = 0; sb[3] = 1; es[3] = 16'h7FFF; ec[3] = 1; eo[3] = 1;
        // wrap-around on add
        av[4] = 16'hFFFF; bv[4] = 16'h0001; ci[4] = 0; sb[4] = 0; es[4] = 16'h0000; ec[4] = 1; eo[4] = 0;
        // signed overflow on add
        av[5] = 16'h7FFF; bv[5] = 16'h0001; ci[5] = 0; sb[5] = 0; es[5] = 16'h8000; ec[5] = 0; eo[5] = 1;
        for (int i = 0; i < 6; i++) begin
            send_one(av[i], bv[i], ci[i], sb[i], lat, so, co, ov);
            vecs++;
            if (lat !== 4) begin
                errs++;
                $display("[TB] FAIL arith%0d_latency: got %0d expected 4", i, lat);
            end
            vecs++;
            if (so !== es[i]) begin
                errs++;
                $display("[TB] FAIL arith%0d_s: got %h expected %h", i, so, es[i]);
            end
            vecs++;
            if (co !== ec[i]) begin
                errs++;
                $display("[TB] FAIL arith%0d_c_out: got %b expected %b", i, co, ec[i]);
            end
            vecs++;
            if (ov !== eo[i]) begin
                errs++;
                $display("[TB] FAIL arith%0d_ovf: got %b expected %b", i, ov, eo[i]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] got [4];
        int           at  [4];
        int           n;
        n = 0;
        bus.out_ready = 1'b1;
        bus.sub       = 1'b0;
        bus.c_in      = 1'b0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (cyc < 4) begin
                bus.in_valid = 1'b1;
                bus.a        = 16'(cyc + 1);
                bus.b        = 16'(cyc + 1);
            end else begin
                bus.in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            if (bus.out_valid) begin
                if (n < 4) begin
                    got[n] = bus.s;
                    at[n]  = cyc;
                end
                n++;
            end
        end
        vecs++;
        if (n !== 4) begin
            errs++;
            $display("[TB] FAIL b2b_count: got %0d results expected 4", n);
        end
        for (int i = 0; i < 4 && i < n; i++) begin
            vecs++;
            if (got[i] !== 16'(2 * (i + 1))) begin
                errs++;
                $display("[TB] FAIL b2b_s%0d: got %h expected %h", i, got[i], 16'(2 * (i + 1)));
            end
            vecs++;
            if (at[i] !== i + 4) begin
                errs++;
                $display("[TB] FAIL b2b_cycle%0d: got %0d expected %0d", i, at[i], i + 4);
            end
        end
    endtask

    task automatic test_backpressure();
        int           next_beat;
        int           ridx;
        logic         fire_in;
        logic         fire_out;
        logic         stalled;
        logic [W-1:0] held;
        logic         saw_low;
        next_beat = 1;
        ridx      = 0;
        saw_low   = 1'b0;
        bus.sub   = 1'b0;
        bus.c_in  = 1'b0;
        for (int cyc = 0; cyc < 60 && ridx < 8; cyc++) begin
            bus.out_ready = !(cyc >= 6 && cyc < 11);
            if (next_beat <= 8) begin
                bus.in_valid = 1'b1;
                bus.a        = 16'(next_beat);
                bus.b        = 16'(next_beat * 16);
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            fire_in  = bus.in_valid & bus.in_ready;
            fire_out = bus.out_valid & bus.out_ready;
            stalled  = bus.out_valid & ~bus.out_ready;
            held     = bus.s;
            if (!bus.in_ready) saw_low = 1'b1;
            @(posedge clk);
            #1;
            if (fire_in) next_beat++;
            if (fire_out) begin
                vecs++;
                if (held !== 16'(17 * (ridx + 1))) begin
                    errs++;
                    $display("[TB] FAIL bp_result%0d: got %h expected %h", ridx, held, 16'(17 * (ridx + 1)));
                end
                ridx++;
            end
            if (stalled) begin
                vecs++;
                if (bus.out_valid !== 1'b1) begin
                    errs++;
                    $display("[TB] FAIL bp_hold_valid: got %b expected 1", bus.out_valid);
                end
                vecs++;
                if (bus.s !== held) begin
                    errs++;
                    $display("[TB] FAIL bp_hold_s: got %h expected %h", bus.s, held);
                end
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        vecs++;
        if (ridx !== 8) begin
            errs++;
            $display("[TB] FAIL bp_count: got %0d results expected 8", ridx);
        end
        vecs++;
        if (next_beat !== 9) begin
            errs++;
            $display("[TB] FAIL bp_accepted: got %0d beats expected 8", next_beat - 1);
        end
        vecs++;
        if (saw_low !== 1'b1) begin
            errs++;
            $display("[TB] FAIL bp_in_ready_drop: got %b expected 1", saw_low);
        end
        repeat (6) @(posedge clk);
        #1;
        vecs++;
        if (bus.out_valid !== 1'b0) begin
            errs++;
            $display("[TB] FAIL bp_extra_result: got out_valid %b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_reset_in_flight();
        logic         stale;
        int           lat;
        logic [W-1:0] so;
        logic         co;
        logic         ov;
        bus.out_ready = 1'b1;
        bus.sub       = 1'b0;
        bus.c_in      = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.a        = 16'h0100 * 16'(i + 1);
            bus.b        = 16'h0011;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        vecs++;
        if (bus.out_valid !== 1'b0) begin
            errs++;
            $display("[TB] FAIL rif_out_valid: got %b expected 0", bus.out_valid);
        end
        vecs++;
        if (bus.s !== 16'h0000) begin
            errs++;
            $display("[TB] FAIL rif_s: got %h expected 0000", bus.s);
        end
        stale = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) stale = 1'b1;
        end
        vecs++;
        if (stale !== 1'b0) begin
            errs++;
            $display("[TB] FAIL rif_stale: got %b expected 0", stale);
        end
        send_one(16'h0003, 16'h0004, 1'b0, 1'b0, lat, so, co, ov);
        vecs++;
        if (lat !== 4) begin
            errs++;
            $display("[TB] FAIL rif_fresh_latency: got %0d expected 4", lat);
        end
        vecs++;
        if (so !== 16'h0007) begin
            errs++;
            $display("[TB] FAIL rif_fresh_s: got %h expected 0007", so);
        end
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        test_reset();
        test_arith();
        test_back_to_back();
        test_backpressure();
        test_reset_in_flight();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
